// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter
// N-manager Wishbone classic arbiter. One manager owns the downstream bus
// from grant until it drops CYC. Ownership is chosen by round-robin or by
// fixed priority. A one-cycle RELEASE gap separates consecutive owners.
// Optional feature: define WB_ARB_TIMEOUT_EN to add an ack watchdog. The
// watchdog returns 32'hDEAD_BEEF with an ACK after TIMEOUT_CYCLES stalled cycles.

module wishbone_rr_arbiter #(
  parameter int NUM_MANAGERS   = 2,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [32*NUM_MANAGERS-1:0]  A_ADR_I,
  input  logic [32*NUM_MANAGERS-1:0]  A_DAT_I,
  input  logic [4*NUM_MANAGERS-1:0]   A_SEL_I,
  input  logic [NUM_MANAGERS-1:0]     A_WE_I,
  input  logic [NUM_MANAGERS-1:0]     A_STB_I,
  input  logic [NUM_MANAGERS-1:0]     A_CYC_I,
  output logic [32*NUM_MANAGERS-1:0]  A_DAT_O,
  output logic [NUM_MANAGERS-1:0]     A_ACK_O,
  input  logic [31:0]                 DAT_I,
  input  logic                        ACK_I,
  output logic [31:0]                 ADR_O,
  output logic [31:0]                 DAT_O,
  output logic [3:0]                  SEL_O,
  output logic                        WE_O,
  output logic                        STB_O,
  output logic                        CYC_O,
  output logic [NUM_MANAGERS-1:0]     GNT_O
);

  localparam int IDW = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;

  // Elaboration-time guard on parameter ranges.
  if (NUM_MANAGERS < 1 || NUM_MANAGERS > 16) begin : g_bad_num_managers
    $error("wishbone_rr_arbiter: NUM_MANAGERS must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wishbone_rr_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_gnt_idx;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] w_winner;
  logic [IDW-1:0] w_cand;
  logic           w_found;
  logic           w_in_grant;
  logic           w_owner_cyc;
  logic           w_timeout;

  assign w_in_grant  = (r_state == S_GRANT);
  assign w_owner_cyc = A_CYC_I[r_gnt_idx];

  // Pick the next owner from the current requests (used in IDLE only).
  // NOTE: every variable assigned in this block gets a default first. A path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NUM_MANAGERS - 1; i >= 0; i--) begin
        if (A_CYC_I[i]) w_winner = IDW'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_MANAGERS; k++) begin
        w_cand = IDW'((int'(r_last_grant) + k) % NUM_MANAGERS);
        if (!w_found && A_CYC_I[w_cand]) begin
          w_winner = w_cand;
          w_found  = 1'b1;
        end
      end
    end
  end

  // Next-state logic. Ownership ends only when the owner drops CYC.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (|A_CYC_I)     w_state_nxt = S_GRANT;
      S_GRANT:   if (!w_owner_cyc) w_state_nxt = S_RELEASE;
      S_RELEASE:                   w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // State, current owner and round-robin history registers.
  // NOTE: clocked state uses non-blocking assignments. All registers then
  // update together from pre-edge values, and simulation matches hardware.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= S_IDLE;
      r_gnt_idx    <= '0;
      r_last_grant <= IDW'(NUM_MANAGERS - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && (|A_CYC_I)) r_gnt_idx <= w_winner;
      if (w_in_grant && !w_owner_cyc)     r_last_grant <= r_gnt_idx;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        w_stall;

  assign w_stall   = w_in_grant && A_STB_I[r_gnt_idx] && !ACK_I;
  assign w_timeout = w_stall && (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts stalled strobe cycles of the current owner.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_to_cnt <= '0;
    end else if (!w_in_grant || ACK_I || w_timeout) begin
      r_to_cnt <= '0;
    end else if (w_stall) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Request mux toward the decoder and response routing back to the owner only.
  always_comb begin
    GNT_O   = '0;
    A_ACK_O = '0;
    A_DAT_O = '0;
    ADR_O   = '0;
    DAT_O   = '0;
    SEL_O   = '0;
    WE_O    = 1'b0;
    STB_O   = 1'b0;
    CYC_O   = 1'b0;
    if (w_in_grant) begin
      GNT_O[r_gnt_idx]                = 1'b1;
      ADR_O                           = A_ADR_I[32*r_gnt_idx +: 32];
      DAT_O                           = A_DAT_I[32*r_gnt_idx +: 32];
      SEL_O                           = A_SEL_I[4*r_gnt_idx +: 4];
      WE_O                            = A_WE_I[r_gnt_idx];
      STB_O                           = A_STB_I[r_gnt_idx];
      CYC_O                           = A_CYC_I[r_gnt_idx];
      A_ACK_O[r_gnt_idx]              = ACK_I;
      A_DAT_O[32*r_gnt_idx +: 32]     = DAT_I;
      if (w_timeout) begin
        // Error termination: fake ACK with a marker word and a dropped strobe.
        A_ACK_O[r_gnt_idx]            = 1'b1;
        A_DAT_O[32*r_gnt_idx +: 32]   = 32'hDEAD_BEEF;
        STB_O                         = 1'b0;
        CYC_O                         = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// tb_wishbone_rr_arbiter
// Directed bench. Two 4-manager arbiters share one stimulus: one round-robin
// and one fixed-priority. Inputs change just after the falling edge, and
// outputs are sampled at the falling edge or 1-2 ns after an input change.

module tb_wishbone_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic [32*N-1:0] adr, wdat;
  logic [4*N-1:0]  sel;
  logic [N-1:0]    we, stb, cyc;
  logic [31:0]     dat_i;
  logic            ack_i;

  logic [32*N-1:0] rr_a_dat, fp_a_dat;
  logic [N-1:0]    rr_a_ack, fp_a_ack, rr_gnt, fp_gnt;
  logic [31:0]     rr_adr, fp_adr, rr_dat, fp_dat;
  logic [3:0]      rr_sel, fp_sel;
  logic            rr_we, fp_we, rr_stb, fp_stb, rr_cyc, fp_cyc;

  // Selected instance for the shared serve task.
  logic            use_fp = 1'b0;
  logic [32*N-1:0] m_a_dat;
  logic [N-1:0]    m_a_ack, m_gnt;
  logic [31:0]     m_adr, m_dat;
  logic [3:0]      m_sel;
  logic            m_we, m_cyc;

  assign m_a_dat = use_fp ? fp_a_dat : rr_a_dat;
  assign m_a_ack = use_fp ? fp_a_ack : rr_a_ack;
  assign m_gnt   = use_fp ? fp_gnt   : rr_gnt;
  assign m_adr   = use_fp ? fp_adr   : rr_adr;
  assign m_dat   = use_fp ? fp_dat   : rr_dat;
  assign m_sel   = use_fp ? fp_sel   : rr_sel;
  assign m_we    = use_fp ? fp_we    : rr_we;
  assign m_cyc   = use_fp ? fp_cyc   : rr_cyc;

  always #5 CLK = ~CLK;

  wishbone_rr_arbiter #(.NUM_MANAGERS(N), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO)) u_rr (
    .CLK(CLK), .nRST(nRST),
    .A_ADR_I(adr), .A_DAT_I(wdat), .A_SEL_I(sel), .A_WE_I(we), .A_STB_I(stb), .A_CYC_I(cyc),
    .A_DAT_O(rr_a_dat), .A_ACK_O(rr_a_ack),
    .DAT_I(dat_i), .ACK_I(ack_i),
    .ADR_O(rr_adr), .DAT_O(rr_dat), .SEL_O(rr_sel), .WE_O(rr_we), .STB_O(rr_stb), .CYC_O(rr_cyc),
    .GNT_O(rr_gnt)
  );

  wishbone_rr_arbiter #(.NUM_MANAGERS(N), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO)) u_fp (
    .CLK(CLK), .nRST(nRST),
    .A_ADR_I(adr), .A_DAT_I(wdat), .A_SEL_I(sel), .A_WE_I(we), .A_STB_I(stb), .A_CYC_I(cyc),
    .A_DAT_O(fp_a_dat), .A_ACK_O(fp_a_ack),
    .DAT_I(dat_i), .ACK_I(ack_i),
    .ADR_O(fp_adr), .DAT_O(fp_dat), .SEL_O(fp_sel), .WE_O(fp_we), .STB_O(fp_stb), .CYC_O(fp_cyc),
    .GNT_O(fp_gnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [32*N-1:0] slot(input int g, input logic [31:0] v);
    logic [32*N-1:0] r;
    r           = '0;
    r[32*g +: 32] = v;
    return r;
  endfunction

  function automatic logic [31:0] exp_adr(input int g);
    return 32'h3000_0000 + 32'(g) * 32'h100;
  endfunction

  function automatic logic [31:0] exp_wdat(input int g);
    return 32'hA000_0000 + 32'(g);
  endfunction

  // Called at the falling edge where manager g should hold the grant. Runs
  // `beats` acked transfers. The last ACK coincides with CYC dropping, and
  // the call returns at the falling edge where the next owner shows up.
  task automatic serve(input int g, input int beats, input logic rereq);
    check($sformatf("gnt_m%0d", g),  m_gnt, onehot(g));
    check($sformatf("adr_m%0d", g),  m_adr, exp_adr(g));
    check($sformatf("wdat_m%0d", g), m_dat, exp_wdat(g));
    check($sformatf("sel_m%0d", g),  m_sel, 4'(g + 1));
    check($sformatf("we_m%0d", g),   m_we, logic'(g % 2));
    check($sformatf("cyc_m%0d", g),  m_cyc, 1'b1);
    for (int b = 0; b < beats - 1; b++) begin
      #1 ack_i = 1'b1; dat_i = 32'hC0DE_0000 + 32'(16 * g + b);
      @(negedge CLK);
      check($sformatf("ack_m%0d_b%0d", g, b), m_a_ack, onehot(g));
      check($sformatf("rdat_m%0d_b%0d", g, b), m_a_dat, slot(g, 32'hC0DE_0000 + 32'(16 * g + b)));
      #1 ack_i = 1'b0;
      @(negedge CLK);
      check($sformatf("hold_gnt_m%0d_b%0d", g, b), m_gnt, onehot(g));
      check($sformatf("noack_m%0d_b%0d", g, b), m_a_ack, '0);
    end
    #1 ack_i = 1'b1; dat_i = 32'hBEEF_0000 + 32'(g); cyc[g] = 1'b0; stb[g] = 1'b0;
    #1;
    check($sformatf("drop_ack_m%0d", g), m_a_ack, onehot(g));
    check($sformatf("drop_rdat_m%0d", g), m_a_dat, slot(g, 32'hBEEF_0000 + 32'(g)));
    check($sformatf("drop_cyc_m%0d", g), m_cyc, 1'b0);
    @(negedge CLK);
    check($sformatf("rel_gnt_m%0d", g), m_gnt, '0);
    check($sformatf("rel_cyc_m%0d", g), m_cyc, 1'b0);
    check($sformatf("rel_stray_ack_m%0d", g), m_a_ack, '0);
    #1 ack_i = 1'b0; dat_i = '0; cyc[g] = rereq; stb[g] = rereq;
    @(negedge CLK);
    check($sformatf("idle_gnt_m%0d", g), m_gnt, '0);
    check($sformatf("idle_cyc_m%0d", g), m_cyc, 1'b0);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      adr[32*i +: 32]  = exp_adr(i);
      wdat[32*i +: 32] = exp_wdat(i);
      sel[4*i +: 4]    = 4'(i + 1);
      we[i]            = logic'(i % 2);
    end
    cyc = '0; stb = '0; ack_i = 1'b0; dat_i = '0;

    // Reset state, with a stray ACK present.
    #2 ack_i = 1'b1; dat_i = 32'hFFFF_FFFF;
    #1;
    check("rst_gnt", rr_gnt, '0);
    check("rst_cyc", rr_cyc, 1'b0);
    check("rst_stb", rr_stb, 1'b0);
    check("rst_adr", rr_adr, '0);
    check("rst_ack", rr_a_ack, '0);
    check("rst_adat", rr_a_dat, '0);
    ack_i = 1'b0; dat_i = '0;
    @(negedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    check("idle_after_rst", rr_gnt, '0);

    // T1: single read by manager 0, slave acks after two wait cycles.
    #1 cyc[0] = 1'b1; stb[0] = 1'b1;
    #1 check("t1_no_cyc_same_cycle", rr_cyc, 1'b0);
    @(negedge CLK);
    check("t1_cyc", rr_cyc, 1'b1);
    check("t1_stb", rr_stb, 1'b1);
    check("t1_gnt", rr_gnt, 4'b0001);
    check("t1_adr", rr_adr, 32'h3000_0000);
    check("t1_wait_ack0", rr_a_ack, '0);
    @(negedge CLK);
    check("t1_wait_ack1", rr_a_ack, '0);
    #1 ack_i = 1'b1; dat_i = 32'h1234_5678;
    @(negedge CLK);
    check("t1_ack", rr_a_ack, 4'b0001);
    check("t1_rdat", rr_a_dat, slot(0, 32'h1234_5678));
    #1 ack_i = 1'b0; dat_i = '0; cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge CLK);
    check("t1_rel_gnt", rr_gnt, '0);
    #1 ack_i = 1'b1; dat_i = 32'hFFFF_FFFF;
    #1;
    check("t1_rel_stray_ack", rr_a_ack, '0);
    check("t1_rel_stray_dat", rr_a_dat, '0);
    @(negedge CLK);
    check("t1_idle_stray_ack", rr_a_ack, '0);
    #1 ack_i = 1'b0; dat_i = '0;

    // T6: manager 2 owns the bus, then reset arrives mid-transfer.
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(negedge CLK);
    check("t6_gnt", rr_gnt, 4'b0100);
    #1 ack_i = 1'b1; dat_i = 32'h5555_AAAA;
    #1 check("t6_ack_before_rst", rr_a_ack, 4'b0100);
    nRST = 1'b0;
    #1;
    check("t6_rst_cyc", rr_cyc, 1'b0);
    check("t6_rst_gnt", rr_gnt, '0);
    check("t6_rst_ack", rr_a_ack, '0);
    ack_i = 1'b0; dat_i = '0; cyc = '1; stb = '1;
    @(negedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);

    // T2 + T4: all four request. Round-robin order 0,1,2,3,0, then 1.
    serve(0, 2, 1'b1);
    serve(1, 2, 1'b1);
    serve(2, 2, 1'b1);
    serve(3, 2, 1'b1);
    serve(0, 2, 1'b0);
    check("t2_wrap_gnt", rr_gnt, 4'b0010);
    #1 cyc = '0; stb = '0;
    @(negedge CLK);
    @(negedge CLK);
    check("t2_idle", rr_gnt, '0);

    // T3: fixed priority. Manager 3 bursts, and manager 1 joins mid-burst.
    #1 nRST = 1'b0;
    #1 nRST = 1'b1;
    use_fp = 1'b1;
    cyc[3] = 1'b1; stb[3] = 1'b1;
    @(negedge CLK);
    cyc[1] = 1'b1; stb[1] = 1'b1;
    serve(3, 3, 1'b1);
    check("t3_rr_gnt_after_m3", rr_gnt, 4'b0010);
    serve(1, 1, 1'b1);
    // Managers 1 and 3 both request now. Priority picks 1; round-robin picks 3.
    check("t3_fp_prio", fp_gnt, 4'b0010);
    check("t3_rr_rotates", rr_gnt, 4'b1000);
    use_fp = 1'b0;
    #1 cyc = '0; stb = '0;
    @(negedge CLK);
    @(negedge CLK);

    // T5: the slave never acks. The watchdog fires on the 8th stalled cycle if built in.
    #1 nRST = 1'b0;
    #1 nRST = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      check($sformatf("t5_gnt_k%0d", k), rr_gnt, 4'b0001);
      if (TO_EN && k == TO) begin
        check($sformatf("t5_to_ack_k%0d", k), rr_a_ack, 4'b0001);
        check($sformatf("t5_to_dat_k%0d", k), rr_a_dat, slot(0, 32'hDEAD_BEEF));
        check($sformatf("t5_to_stb_k%0d", k), rr_stb, 1'b0);
        check($sformatf("t5_to_cyc_k%0d", k), rr_cyc, 1'b0);
      end else begin
        check($sformatf("t5_wait_ack_k%0d", k), rr_a_ack, '0);
        check($sformatf("t5_wait_stb_k%0d", k), rr_stb, 1'b1);
      end
    end
    #1 cyc = '0; stb = '0;
    @(negedge CLK);
    @(negedge CLK);
    check("t5_idle", rr_gnt, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
